mm_burst_reader: RTL and testbench
==================================

Name: mm_burst_reader

Overview:
Burst read engine that drives one read port of multimemory: r_addr/r_avalid/r_aready out, r_dvalid/r_data back. Accepts a command (start address, length), issues consecutive word reads, collects returned data in an internal FIFO and presents it as a valid/ready stream with a last flag. Credit accounting guarantees r_dvalid, which cannot be backpressured, never overflows the FIFO. One instance sits directly upstream of each multimemory requester port.

Parameters:
DATA_WIDTH, 16, width of r_data / out_data
ADDR_WIDTH, 16, width of r_addr / cmd_addr
LEN_WIDTH, 8, width of cmd_len; burst = cmd_len+1 words (1..2^LEN_WIDTH)
FIFO_DEPTH, 8, response FIFO entries; power of two, >=2; also max credits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_addr  in  ADDR_WIDTH  first word address
cmd_len  in  LEN_WIDTH  burst length minus one
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
r_addr  out  ADDR_WIDTH  read address to multimemory
r_avalid  out  1  address valid
r_aready  in  1  address accepted by multimemory
r_dvalid  in  1  read data valid (no backpressure, in-order)
r_data  in  DATA_WIDTH  read data
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  final word of current burst
busy  out  1  command in progress (not IDLE)
err_unexp  out  1  sticky: r_dvalid seen with zero outstanding reads

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: cmd_ready=1, r_avalid=0, r_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, err_unexp=0; FIFO empty; counters 0.
- States: IDLE -> ISSUE on cmd handshake (latch addr, remaining=cmd_len+1, cmd_ready=0 next cycle). ISSUE -> DRAIN when last address accepted. DRAIN -> IDLE when outstanding=0 and FIFO empty after last word transferred (out_valid&out_ready&out_last). cmd_ready=1 only in IDLE.
- Credits: credit_used = outstanding + fifo_count. In ISSUE, r_avalid asserted next cycle only if credit_used + (address in flight this cycle) < FIFO_DEPTH. An address handshake increments outstanding; r_dvalid decrements outstanding and writes FIFO; out handshake decrements fifo_count. Simultaneous inc/dec net correctly.
- r_avalid/r_addr held stable until r_aready; r_avalid never deasserts without handshake. After handshake r_addr = r_addr+1 (wrap modulo 2^ADDR_WIDTH, 16'hFFFF -> 16'h0000); back-to-back issue at 1/cycle while credits permit.
- Latency: word captured on r_dvalid cycle appears on out_valid the following cycle. out_data/out_last stable while out_valid&!out_ready.
- out_last set on word number cmd_len+1 of the burst, tracked by a return counter.
- r_dvalid while outstanding=0: data dropped, err_unexp set (cleared only by rst).
- FIFO full cannot occur by construction; bench asserts fifo_count<=FIFO_DEPTH.
- Reset mid-burst: state returns to IDLE immediately; responses arriving afterward count as unexpected (err_unexp=1).

Optional Feature:
MM_BURST_READER_STRIDE_EN: adds input cmd_stride [ADDR_WIDTH-1:0], latched with the command; address increments by cmd_stride (modulo 2^ADDR_WIDTH; stride 0 rereads one address). Without the macro, the port is absent and the increment is fixed at 1.

Test Plan:
- Memory mem[i]=i; cmd addr=16'h0010 len=3, r_aready=1, out_ready=1 -> out_data 0010,0011,0012,0013, out_last only on 0013, busy falls after last word, cmd_ready=1.
- FIFO_DEPTH=8, len=31, out_ready=0 -> exactly 8 address handshakes then r_avalid=0; raise out_ready -> all 32 words in order, no data lost.
- r_aready toggled pseudo-randomly (50%) with len=15 -> r_addr stable while stalled, 16 sequential addresses, 16 correct words.
- cmd addr=16'hFFFE len=3 -> addresses FFFE,FFFF,0000,0001; data matches.
- Inject r_dvalid while IDLE -> err_unexp=1, out_valid stays 0; assert rst mid-burst (after 3 of 10 words) -> IDLE next cycle, all outputs at reset values.
- With MM_BURST_READER_STRIDE_EN, addr=16'h0100 stride=4 len=2 -> reads 0100,0104,0108; stride 0 -> three reads of 0100.

Source files
------------

// File: rtl/mm_burst_reader.sv
// mm_burst_reader: burst read engine for one multimemory read port.
// Takes a command (address, len), issues len+1 word reads, buffers the
// returned words and presents them as a valid/ready stream with a last flag.
// Reads are issued only against free buffer space, so r_dvalid (which
// cannot be stalled) never overflows.
// Optional build macro MM_BURST_READER_STRIDE_EN adds cmd_stride.
module mm_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
`ifdef MM_BURST_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_avalid,
    input  logic                  r_aready,
    input  logic                  r_dvalid,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_unexp
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, step;
    logic                  avalid_q, avalid_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, ret_cnt_q, ret_cnt_d;
    logic [CW-1:0]         outstanding_q, outstanding_d, mem_cnt_q, mem_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  err_q, err_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic                  mem_we;
    logic                  cmd_hs, a_hs, d_ok, o_hs, rd_last;
    logic [CW:0]           credit_used;

`ifdef MM_BURST_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    assign cmd_hs  = cmd_valid & cmd_ready_q;
    assign a_hs    = avalid_q & r_aready;
    assign d_ok    = r_dvalid & (outstanding_q != '0);
    assign o_hs    = out_valid_q & out_ready;
    assign rd_last = (ret_cnt_q == len_q);
    // Everything already promised a buffer slot: in flight plus held words.
    assign credit_used = (CW+1)'(outstanding_q) + (CW+1)'(mem_cnt_q) + (CW+1)'(out_valid_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_hs) state_d = S_ISSUE;
            S_ISSUE: if (a_hs && remaining_q == RW'(1)) state_d = S_DRAIN;
            S_DRAIN: if (o_hs && out_last_q && outstanding_q == '0 && mem_cnt_q == '0)
                         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered from the next state
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // Address issue: hold until accepted, re-arm only while credits remain
    always_comb begin
        addr_d      = addr_q;
        avalid_d    = avalid_q;
        remaining_d = remaining_q;
        len_d       = len_q;
`ifdef MM_BURST_READER_STRIDE_EN
        stride_d    = stride_q;
`endif
        if (cmd_hs) begin
            addr_d      = cmd_addr;
            remaining_d = RW'(cmd_len) + RW'(1);
            len_d       = cmd_len;
            avalid_d    = 1'b1;
`ifdef MM_BURST_READER_STRIDE_EN
            stride_d    = cmd_stride;
`endif
        end else if (state_q == S_ISSUE) begin
            if (a_hs) begin
                addr_d      = addr_q + step;
                remaining_d = remaining_q - RW'(1);
            end
            if (avalid_q && !r_aready)
                avalid_d = 1'b1;
            else
                avalid_d = (remaining_d != '0) &&
                           ((credit_used + (CW+1)'(a_hs)) < (CW+1)'(FIFO_DEPTH));
        end else begin
            avalid_d = 1'b0;
        end
    end

    // Response side: outstanding count, return counter, FIFO with output register.
    // When the output register is free and the FIFO is empty, a returning word
    // bypasses straight into it to get the one-cycle latency.
    always_comb begin
        outstanding_d = outstanding_q + CW'(a_hs) - CW'(d_ok);
        err_d         = err_q | (r_dvalid & (outstanding_q == '0));
        ret_cnt_d     = ret_cnt_q;
        if (d_ok)   ret_cnt_d = ret_cnt_q + LEN_WIDTH'(1);
        if (cmd_hs) ret_cnt_d = '0;

        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rd_ptr_d    = rd_ptr_q;
        mem_we      = 1'b0;
        mem_cnt_d   = mem_cnt_q;
        if (!out_valid_q || out_ready) begin
            if (mem_cnt_q != '0) begin
                out_valid_d              = 1'b1;
                {out_last_d, out_data_d} = mem[rd_ptr_q];
                rd_ptr_d                 = rd_ptr_q + PW'(1);
                mem_we                   = d_ok;
                mem_cnt_d                = mem_cnt_q - CW'(1) + CW'(d_ok);
            end else if (d_ok) begin
                out_valid_d = 1'b1;
                out_data_d  = r_data;
                out_last_d  = rd_last;
            end
        end else begin
            mem_we    = d_ok;
            mem_cnt_d = mem_cnt_q + CW'(d_ok);
        end
        wr_ptr_d = wr_ptr_q + PW'(mem_we);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            avalid_q      <= 1'b0;
            remaining_q   <= '0;
            len_q         <= '0;
            ret_cnt_q     <= '0;
            outstanding_q <= '0;
            mem_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
`ifdef MM_BURST_READER_STRIDE_EN
            stride_q      <= '0;
`endif
        end else begin
            addr_q        <= addr_d;
            avalid_q      <= avalid_d;
            remaining_q   <= remaining_d;
            len_q         <= len_d;
            ret_cnt_q     <= ret_cnt_d;
            outstanding_q <= outstanding_d;
            mem_cnt_q     <= mem_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            err_q         <= err_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
`ifdef MM_BURST_READER_STRIDE_EN
            stride_q      <= stride_d;
`endif
        end
    end

    // FIFO storage: data plus its last flag
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= {rd_last, r_data};
    end

    assign cmd_ready = cmd_ready_q;
    assign r_addr    = addr_q;
    assign r_avalid  = avalid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err_unexp = err_q;
endmodule

// File: tb/tb_mm_burst_reader.sv
// Directed bench for mm_burst_reader with a 2-cycle-latency memory model
// where mem[i] = i.
module tb_mm_burst_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_valid = 1'b0;
`ifdef MM_BURST_READER_STRIDE_EN
    logic [15:0] cmd_stride = 16'd1;
`endif
    logic        cmd_ready, r_avalid, out_valid, out_last, busy, err_unexp;
    logic [15:0] r_addr, out_data;
    logic        r_aready = 1'b1;
    logic        r_dvalid = 1'b0;
    logic [15:0] r_data = '0;
    logic        out_ready = 1'b1;

    int checks = 0, errors = 0;
    bit rnd_mode = 1'b0;
    int inj_cnt = 0, inj_done = 0;
    int stall_viol = 0, fifo_viol = 0;
    logic [16:0] rx[$];
    logic [15:0] alog[$];
    int rx_base = 0, al_base = 0;

    // responder pipeline state
    logic        pv0 = 0, pv1 = 0, prev_av = 0, prev_ar = 0;
    logic [15:0] pd0 = 0, pd1 = 0, prev_addr = 0;

    mm_burst_reader dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
`ifdef MM_BURST_READER_STRIDE_EN
        .cmd_stride(cmd_stride),
`endif
        .cmd_ready(cmd_ready),
        .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
        .r_dvalid(r_dvalid), .r_data(r_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Memory model, address logger, stream collector, invariants (negedge)
    always @(negedge clk) begin
        r_aready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_av && !prev_ar && !(r_avalid && r_addr == prev_addr)) stall_viol++;
        prev_av = r_avalid; prev_ar = r_aready; prev_addr = r_addr;
        r_dvalid = pv1; r_data = pd1;
        if (inj_cnt != inj_done) begin
            r_dvalid = 1'b1; r_data = 16'hBEEF; inj_done = inj_cnt;
        end
        pv1 = pv0; pd1 = pd0;
        pv0 = r_avalid && r_aready; pd0 = r_addr;
        if (r_avalid && r_aready) alog.push_back(r_addr);
        if (out_valid && out_ready) rx.push_back({out_last, out_data});
        if (32'(dut.mem_cnt_q) + 32'(dut.out_valid_q) > 8) fifo_viol++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [15:0] a, input logic [7:0] l, input logic [15:0] s);
        int n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        rx_base = rx.size(); al_base = alog.size();
        cmd_addr = a; cmd_len = l;
`ifdef MM_BURST_READER_STRIDE_EN
        cmd_stride = s;
`else
        if (s != 16'd1) $display("note: stride ignored");
`endif
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk({tag, "_idle"}, 32'(n < budget), 32'd1);
    endtask

    // words and addresses must both be base + i*stride; last only on final word
    task automatic check_burst(input string tag, input logic [15:0] base,
                               input logic [15:0] stride, input int n);
        int bad_d = 0, bad_a = 0;
        logic [15:0] e;
        chk({tag, "_nwords"}, 32'(rx.size() - rx_base), 32'(n));
        chk({tag, "_naddrs"}, 32'(alog.size() - al_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = base + 16'(i) * stride;
            if (rx_base + i >= rx.size() || rx[rx_base + i] !== {(i == n - 1), e}) bad_d++;
            if (al_base + i >= alog.size() || alog[al_base + i] !== e) bad_a++;
        end
        chk({tag, "_data"}, 32'(bad_d), 32'd0);
        chk({tag, "_addr"}, 32'(bad_a), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_r_avalid"},  32'(r_avalid),  32'd0);
        chk({tag, "_r_addr"},    32'(r_addr),    32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_err"},       32'(err_unexp), 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        tick(3);
        check_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Basic 4-word burst
        start_cmd(16'h0010, 8'd3, 16'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_cmd_ready_low", 32'(cmd_ready), 32'd0);
        wait_idle("basic", 100);
        check_burst("basic", 16'h0010, 16'd1, 4);
        chk("basic_cmd_ready", 32'(cmd_ready), 32'd1);

        // Credit limit: no consumer, only FIFO_DEPTH reads go out
        out_ready = 1'b0;
        start_cmd(16'h0020, 8'd31, 16'd1);
        tick(40);
        chk("credit_naddr", 32'(alog.size() - al_base), 32'd8);
        chk("credit_avalid", 32'(r_avalid), 32'd0);
        chk("credit_out_valid", 32'(out_valid), 32'd1);
        chk("credit_head", 32'(out_data), 32'h0020);
        out_ready = 1'b1;
        wait_idle("credit", 400);
        check_burst("credit", 16'h0020, 16'd1, 32);

        // Random address stalls
        rnd_mode = 1'b1;
        start_cmd(16'h0100, 8'd15, 16'd1);
        wait_idle("stall", 500);
        check_burst("stall", 16'h0100, 16'd1, 16);
        chk("stall_stable", 32'(stall_viol), 32'd0);
        rnd_mode = 1'b0;

        // Address wrap
        start_cmd(16'hFFFE, 8'd3, 16'd1);
        wait_idle("wrap", 100);
        check_burst("wrap", 16'hFFFE, 16'd1, 4);

`ifdef MM_BURST_READER_STRIDE_EN
        start_cmd(16'h0100, 8'd2, 16'd4);
        wait_idle("stride4", 100);
        check_burst("stride4", 16'h0100, 16'd4, 3);
        start_cmd(16'h0100, 8'd2, 16'd0);
        wait_idle("stride0", 100);
        check_burst("stride0", 16'h0100, 16'd0, 3);
`endif

        // Unexpected response while idle
        rx_base = rx.size();
        inj_cnt++;
        tick(3);
        chk("inj_err", 32'(err_unexp), 32'd1);
        chk("inj_out_valid", 32'(out_valid), 32'd0);
        chk("inj_nwords", 32'(rx.size() - rx_base), 32'd0);

        // Reset mid-burst after 3 of 10 words
        start_cmd(16'h0200, 8'd9, 16'd1);
        n = 0;
        while (rx.size() - rx_base < 3 && n < 100) begin tick(); n++; end
        chk("midrst_progress", 32'(n < 100), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick(4);
        chk("midrst_late_err", 32'(err_unexp), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);

        chk("fifo_bound", 32'(fifo_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
